// File: rtl/wb_regfile_writer_if.sv
// Writeback-stage bus: pipeline-register outputs in, register-file read ports and packer status out.
// master = upstream/decode side, slave = the writeback block.
interface wb_regfile_writer_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 4
);
    logic              WE;
    logic              PROHIB_WB;
    logic              WE_C;
    logic              WE_V;
    logic              SEL_C;
    logic              SEL_DAT;
    logic [DATA_W-1:0] Do;
    logic [7:0]        Dob;
    logic [DATA_W-1:0] ALU_Result;
    logic [AW-1:0]     Rg;
    logic [AW-1:0]     RA_C;
    logic [AW-1:0]     RB_C;
    logic [AW-1:0]     RA_V;
    logic [DATA_W-1:0] DA_C;
    logic [DATA_W-1:0] DB_C;
    logic [DATA_W-1:0] DA_V;
    logic              Busy;
    logic              Pack_Done;
    logic              Pack_Flush;

    modport master (
        output WE, PROHIB_WB, WE_C, WE_V, SEL_C, SEL_DAT, Do, Dob, ALU_Result, Rg,
               RA_C, RB_C, RA_V,
        input  DA_C, DB_C, DA_V, Busy, Pack_Done, Pack_Flush
    );

    modport slave (
        input  WE, PROHIB_WB, WE_C, WE_V, SEL_C, SEL_DAT, Do, Dob, ALU_Result, Rg,
               RA_C, RB_C, RA_V,
        output DA_C, DB_C, DA_V, Busy, Pack_Done, Pack_Flush
    );
endinterface

// File: rtl/wb_regfile_writer.sv
// Writeback stage: scalar (C) and vector (V) register files plus a byte packer for vector words.
// Optional macro WB_BYPASS_EN forwards same-cycle scalar/full-word vector writes to the read ports.
//
// state | meaning
// IDLE  | no partial vector word held
// PACK  | lanes[0..cnt-1] hold bytes destined for V[tgt]
module wb_regfile_writer #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int LANES  = 4
) (
    input logic               clk,
    input logic               rst,
    wb_regfile_writer_if.slave bus
);
    localparam int AW    = $clog2(NREG);
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {IDLE, PACK} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d, lane_idx;
    logic [AW-1:0]     tgt, tgt_d, pc_addr;
    logic [7:0]        lane [LANES];
    logic [DATA_W-1:0] c_reg [NREG];
    logic [DATA_W-1:0] v_reg [NREG];
    logic [DATA_W-1:0] wdata, partial_word, full_word, pc_data;
    logic              ok, wr_c, byte_wr, word_wr;
    logic              lane_we, pc_we, done_d, flush_d, pack_done_q, pack_flush_q;

    assign ok      = bus.WE & ~bus.PROHIB_WB;
    assign wr_c    = ok & bus.WE_C;
    assign byte_wr = ok & bus.WE_V & ~bus.SEL_C;
    assign word_wr = ok & bus.WE_V & bus.SEL_C;
    assign wdata   = bus.SEL_DAT ? bus.Do : bus.ALU_Result;

    // Lanes at or beyond cnt are stale from an earlier pack, so mask them to zero.
    always_comb begin
        partial_word = '0;
        full_word    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) < cnt) begin
                partial_word[i*8 +: 8] = lane[i];
                full_word[i*8 +: 8]    = lane[i];
            end else if (CNT_W'(i) == cnt) begin
                full_word[i*8 +: 8]    = bus.Dob;
            end
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        tgt_d    = tgt;
        lane_we  = 1'b0;
        lane_idx = cnt;
        pc_we    = 1'b0;
        pc_addr  = tgt;
        pc_data  = partial_word;
        done_d   = 1'b0;
        flush_d  = 1'b0;
        case (state)
            IDLE: begin
                if (byte_wr) begin
                    if (LANES == 1) begin
                        pc_we   = 1'b1;
                        pc_addr = bus.Rg;
                        pc_data = DATA_W'(bus.Dob);
                        done_d  = 1'b1;
                    end else begin
                        lane_we  = 1'b1;
                        lane_idx = '0;
                        tgt_d    = bus.Rg;
                        cnt_d    = CNT_W'(1);
                        state_d  = PACK;
                    end
                end
            end
            PACK: begin
                if (byte_wr) begin
                    lane_we = 1'b1;
                    if (bus.Rg == tgt) begin
                        if (cnt == CNT_W'(LANES - 1)) begin
                            pc_we   = 1'b1;
                            pc_data = full_word;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end else begin
                        pc_we    = 1'b1;
                        flush_d  = 1'b1;
                        lane_idx = '0;
                        tgt_d    = bus.Rg;
                        cnt_d    = CNT_W'(1);
                    end
                end else if (word_wr) begin
                    // Same target: the full word supersedes the partial, nothing to flush.
                    if (bus.Rg != tgt) begin
                        pc_we   = 1'b1;
                        flush_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tgt          <= '0;
            pack_done_q  <= 1'b0;
            pack_flush_q <= 1'b0;
            for (int i = 0; i < LANES; i++) lane[i] <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            tgt          <= tgt_d;
            pack_done_q  <= done_d;
            pack_flush_q <= flush_d;
            if (lane_we) lane[lane_idx] <= bus.Dob;
        end
    end

    // Pack commit is written before the full-word write so the latter wins on a shared address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                c_reg[i] <= '0;
                v_reg[i] <= '0;
            end
        end else begin
            if (wr_c)    c_reg[bus.Rg] <= wdata;
            if (pc_we)   v_reg[pc_addr] <= pc_data;
            if (word_wr) v_reg[bus.Rg] <= wdata;
        end
    end

`ifdef WB_BYPASS_EN
    assign bus.DA_C = (wr_c && bus.RA_C == bus.Rg) ? wdata : c_reg[bus.RA_C];
    assign bus.DB_C = (wr_c && bus.RB_C == bus.Rg) ? wdata : c_reg[bus.RB_C];
    assign bus.DA_V = (word_wr && bus.RA_V == bus.Rg) ? wdata : v_reg[bus.RA_V];
`else
    assign bus.DA_C = c_reg[bus.RA_C];
    assign bus.DB_C = c_reg[bus.RB_C];
    assign bus.DA_V = v_reg[bus.RA_V];
`endif

    assign bus.Busy       = (state == PACK);
    assign bus.Pack_Done  = pack_done_q;
    assign bus.Pack_Flush = pack_flush_q;
endmodule

// File: tb/tb_wb_regfile_writer.sv
// Directed bench for wb_regfile_writer: scalar writes, byte packing, flush, squash, freeze and reset.
// Honours WB_BYPASS_EN for the same-cycle read expectation.
module tb_wb_regfile_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    wb_regfile_writer_if #(.DATA_W(32), .AW(4)) bus ();

    wb_regfile_writer #(.DATA_W(32), .NREG(16), .LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.WE = 1'b1; bus.PROHIB_WB = 1'b0; bus.WE_C = 1'b0; bus.WE_V = 1'b0;
        bus.SEL_C = 1'b0; bus.SEL_DAT = 1'b0;
        bus.Do = '0; bus.Dob = '0; bus.ALU_Result = '0; bus.Rg = '0;
    endtask

    // Advance one edge, then release all write requests before anything is observed.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic put_byte(input logic [3:0] rg, input logic [7:0] b);
        bus.WE_V = 1'b1; bus.SEL_C = 1'b0; bus.Rg = rg; bus.Dob = b;
    endtask

    task automatic put_word(input logic [3:0] rg, input logic [31:0] w);
        bus.WE_V = 1'b1; bus.SEL_C = 1'b1; bus.SEL_DAT = 1'b0; bus.Rg = rg; bus.ALU_Result = w;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.RA_C = 4'd3; bus.RB_C = 4'd0; bus.RA_V = 4'd5;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        checks++; if (bus.Pack_Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.Pack_Done); end
        checks++; if (bus.Pack_Flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", bus.Pack_Flush); end
        checks++; if (bus.DA_C !== 32'h0) begin errors++; $display("FAIL reset_c3: got %h expected 00000000", bus.DA_C); end
        checks++; if (bus.DA_V !== 32'h0) begin errors++; $display("FAIL reset_v5: got %h expected 00000000", bus.DA_V); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_scalar();
        logic [31:0] exp_same;
        bus.RA_C = 4'd3; bus.RB_C = 4'd4;
        bus.WE_C = 1'b1; bus.SEL_DAT = 1'b0; bus.ALU_Result = 32'hDEADBEEF; bus.Do = 32'h0BADCAFE; bus.Rg = 4'd3;
`ifdef WB_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h0;
`endif
        #2;
        checks++; if (bus.DA_C !== exp_same) begin errors++; $display("FAIL scalar_same_cycle: got %h expected %h", bus.DA_C, exp_same); end
        step();
        checks++; if (bus.DA_C !== 32'hDEADBEEF) begin errors++; $display("FAIL scalar_alu: got %h expected deadbeef", bus.DA_C); end
        bus.WE_C = 1'b1; bus.SEL_DAT = 1'b1; bus.Do = 32'h12345678; bus.ALU_Result = 32'hFFFF0000; bus.Rg = 4'd4;
        step();
        checks++; if (bus.DB_C !== 32'h12345678) begin errors++; $display("FAIL scalar_do: got %h expected 12345678", bus.DB_C); end
        checks++; if (bus.DA_C !== 32'hDEADBEEF) begin errors++; $display("FAIL scalar_other_kept: got %h expected deadbeef", bus.DA_C); end
    endtask

    task automatic test_pack_full();
        int busy_cycles = 0;
        logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.RA_V = 4'd5;
        for (int i = 0; i < 4; i++) begin
            put_byte(4'd5, bytes[i]);
            step();
            if (bus.Busy === 1'b1) busy_cycles++;
            if (i < 3) begin
                checks++; if (bus.Pack_Done !== 1'b0) begin errors++; $display("FAIL pack_early_done[%0d]: got %b expected 0", i, bus.Pack_Done); end
            end
        end
        checks++; if (bus.Pack_Done !== 1'b1) begin errors++; $display("FAIL pack_done: got %b expected 1", bus.Pack_Done); end
        checks++; if (bus.DA_V !== 32'h44332211) begin errors++; $display("FAIL pack_v5: got %h expected 44332211", bus.DA_V); end
        checks++; if (busy_cycles != 3) begin errors++; $display("FAIL pack_busy_cycles: got %0d expected 3", busy_cycles); end
        step();
        checks++; if (bus.Pack_Done !== 1'b0) begin errors++; $display("FAIL pack_done_pulse: got %b expected 0", bus.Pack_Done); end
    endtask

    task automatic test_flush();
        bus.RA_V = 4'd2;
        put_byte(4'd2, 8'hAA); step();
        put_byte(4'd2, 8'hBB); step();
        put_byte(4'd7, 8'hCC); step();
        checks++; if (bus.Pack_Flush !== 1'b1) begin errors++; $display("FAIL flush_pulse: got %b expected 1", bus.Pack_Flush); end
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b expected 1", bus.Busy); end
        checks++; if (bus.DA_V !== 32'h0000BBAA) begin errors++; $display("FAIL flush_v2: got %h expected 0000bbaa", bus.DA_V); end
        bus.RA_V = 4'd7;
        put_byte(4'd7, 8'hDD); step();
        checks++; if (bus.Pack_Flush !== 1'b0) begin errors++; $display("FAIL flush_one_cycle: got %b expected 0", bus.Pack_Flush); end
        put_byte(4'd7, 8'hEE); step();
        put_byte(4'd7, 8'hFF); step();
        checks++; if (bus.DA_V !== 32'hFFEEDDCC) begin errors++; $display("FAIL flush_new_pack_v7: got %h expected ffeeddcc", bus.DA_V); end
        checks++; if (bus.Pack_Done !== 1'b1) begin errors++; $display("FAIL flush_new_pack_done: got %b expected 1", bus.Pack_Done); end
    endtask

    task automatic test_prohib();
        bus.RB_C = 4'd4; bus.RA_V = 4'd9;
        put_byte(4'd9, 8'h01); step();
        bus.PROHIB_WB = 1'b1; bus.WE_C = 1'b1; bus.ALU_Result = 32'h1; bus.SEL_DAT = 1'b0;
        put_byte(4'd4, 8'h99);
        step();
        checks++; if (bus.DB_C !== 32'h12345678) begin errors++; $display("FAIL prohib_c4: got %h expected 12345678", bus.DB_C); end
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL prohib_busy: got %b expected 1", bus.Busy); end
        checks++; if (bus.Pack_Flush !== 1'b0) begin errors++; $display("FAIL prohib_no_flush: got %b expected 0", bus.Pack_Flush); end
        put_byte(4'd9, 8'h02); step();
        put_byte(4'd9, 8'h03); step();
        put_byte(4'd9, 8'h04); step();
        checks++; if (bus.DA_V !== 32'h04030201) begin errors++; $display("FAIL prohib_v9: got %h expected 04030201", bus.DA_V); end
        checks++; if (bus.Pack_Done !== 1'b1) begin errors++; $display("FAIL prohib_done: got %b expected 1", bus.Pack_Done); end
    endtask

    task automatic test_freeze();
        int flushes = 0;
        bus.RA_V = 4'd1;
        put_byte(4'd1, 8'h10); step();
        put_byte(4'd1, 8'h20); step();
        for (int i = 0; i < 3; i++) begin
            bus.WE = 1'b0;
            put_byte(4'd3, 8'hF0);
            step();
            if (bus.Pack_Flush === 1'b1) flushes++;
            checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL freeze_busy[%0d]: got %b expected 1", i, bus.Busy); end
        end
        put_byte(4'd1, 8'h30); step();
        if (bus.Pack_Flush === 1'b1) flushes++;
        put_byte(4'd1, 8'h40); step();
        if (bus.Pack_Flush === 1'b1) flushes++;
        checks++; if (bus.DA_V !== 32'h40302010) begin errors++; $display("FAIL freeze_v1: got %h expected 40302010", bus.DA_V); end
        checks++; if (flushes != 0) begin errors++; $display("FAIL freeze_flushes: got %0d expected 0", flushes); end
        checks++; if (bus.Pack_Done !== 1'b1) begin errors++; $display("FAIL freeze_done: got %b expected 1", bus.Pack_Done); end
    endtask

    task automatic test_word_during_pack();
        bus.RA_V = 4'd6;
        put_byte(4'd6, 8'h55); step();
        put_word(4'd6, 32'hCAFEF00D); step();
        checks++; if (bus.DA_V !== 32'hCAFEF00D) begin errors++; $display("FAIL word_same_v6: got %h expected cafef00d", bus.DA_V); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL word_same_busy: got %b expected 0", bus.Busy); end
        checks++; if (bus.Pack_Flush !== 1'b0) begin errors++; $display("FAIL word_same_flush: got %b expected 0", bus.Pack_Flush); end
        bus.RA_V = 4'd8;
        put_byte(4'd8, 8'h66); step();
        put_word(4'd10, 32'h0BADF00D); step();
        checks++; if (bus.DA_V !== 32'h00000066) begin errors++; $display("FAIL word_diff_v8: got %h expected 00000066", bus.DA_V); end
        checks++; if (bus.Pack_Flush !== 1'b1) begin errors++; $display("FAIL word_diff_flush: got %b expected 1", bus.Pack_Flush); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL word_diff_busy: got %b expected 0", bus.Busy); end
        bus.RA_V = 4'd10; #1;
        checks++; if (bus.DA_V !== 32'h0BADF00D) begin errors++; $display("FAIL word_diff_v10: got %h expected 0badf00d", bus.DA_V); end
    endtask

    task automatic test_back_to_back();
        bus.RA_C = 4'd11; bus.RA_V = 4'd11;
        bus.WE_C = 1'b1;
        put_word(4'd11, 32'hA5A5_5A5A);
        step();
        checks++; if (bus.DA_C !== 32'hA5A55A5A) begin errors++; $display("FAIL dual_c11: got %h expected a5a55a5a", bus.DA_C); end
        checks++; if (bus.DA_V !== 32'hA5A55A5A) begin errors++; $display("FAIL dual_v11: got %h expected a5a55a5a", bus.DA_V); end
    endtask

    task automatic test_reset_mid_pack();
        int flushes = 0;
        put_byte(4'd12, 8'h77); step();
        put_byte(4'd12, 8'h88); step();
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", bus.Busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.Busy); end
        for (int a = 0; a < 16; a += 5) begin
            bus.RA_V = 4'(a); #1;
            checks++; if (bus.DA_V !== 32'h0) begin errors++; $display("FAIL midrst_v%0d: got %h expected 00000000", a, bus.DA_V); end
        end
        bus.RA_C = 4'd3; #1;
        checks++; if (bus.DA_C !== 32'h0) begin errors++; $display("FAIL midrst_c3: got %h expected 00000000", bus.DA_C); end
        step();
        rst = 1'b0;
        bus.RA_V = 4'd12;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.Pack_Flush === 1'b1) flushes++;
        end
        checks++; if (flushes != 0) begin errors++; $display("FAIL midrst_flushes: got %0d expected 0", flushes); end
        checks++; if (bus.DA_V !== 32'h0) begin errors++; $display("FAIL midrst_v12_after: got %h expected 00000000", bus.DA_V); end
    endtask

    initial begin
        idle_inputs();
        bus.RA_C = '0; bus.RB_C = '0; bus.RA_V = '0;
        test_reset();
        test_scalar();
        test_pack_full();
        test_flush();
        test_prohib();
        test_freeze();
        test_word_during_pack();
        test_back_to_back();
        test_reset_mid_pack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
